// File: rtl/mem_sched_ctrl.sv
// mem_sched_ctrl
// Memory-bank controller for the non-power-of-two NTT datapath. One start pulse
// runs PASSES passes of DEPTH steps each. Every step produces a common row index,
// a read/write crossbar shift pair and a per-bank write-enable mask. A stall input
// holds the current step. A one-cycle done pulse closes the transform.
module mem_sched_ctrl #(
  parameter int N_BANKS = 257,
  parameter int DEPTH   = 85,
  parameter int STRIDE  = 85,
  parameter int PASSES  = 3,
  parameter int SW      = 9,
  parameter int AW      = 7,
  parameter int PW      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               start,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic               step_en,
  output logic [PW-1:0]      stage,
  output logic               mode,
  output logic [AW-1:0]      row,
  output logic [SW-1:0]      cs1_shift,
  output logic [SW-1:0]      cs2_shift,
  output logic [N_BANKS-1:0] we
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Shift arithmetic runs on SW+1 bits, so a sum of two in-range operands
  // (each below N_BANKS) never overflows before it is folded back.
  localparam logic [SW:0]        N_EXT      = (SW+1)'(N_BANKS);
  localparam logic [SW:0]        STRIDE_EXT = (SW+1)'(STRIDE);
  localparam logic [SW:0]        ONE_EXT    = (SW+1)'(1);
  localparam logic [AW-1:0]      LAST_ROW   = AW'(DEPTH-1);
  localparam logic [AW-1:0]      ROW_ONE    = AW'(1);
  localparam logic [PW-1:0]      LAST_STAGE = PW'(PASSES-1);
  localparam logic [PW-1:0]      STAGE_ONE  = PW'(1);
  localparam logic [N_BANKS-1:0] WE_INIT    = {{(N_BANKS-STRIDE){1'b0}}, {STRIDE{1'b1}}};
  localparam logic [N_BANKS-1:0] WE_ALL     = {N_BANKS{1'b1}};
  localparam logic [N_BANKS-1:0] WE_NONE    = {N_BANKS{1'b0}};
  localparam logic [SW-1:0]      SHIFT_ZERO = {SW{1'b0}};
  localparam logic [AW-1:0]      ROW_ZERO   = {AW{1'b0}};
  localparam logic [PW-1:0]      STAGE_ZERO = {PW{1'b0}};

  // (a + STRIDE) mod N_BANKS for a in [0, N_BANKS-1]
  function automatic logic [SW-1:0] mod_add_stride(input logic [SW-1:0] a);
    logic [SW:0] sum_v;
    sum_v = {1'b0, a} + STRIDE_EXT;
    if (sum_v >= N_EXT) begin
      sum_v = sum_v - N_EXT;
    end else begin
      sum_v = sum_v;
    end
    return sum_v[SW-1:0];
  endfunction

  // (a - 1) mod N_BANKS, computed as a + N_BANKS - 1 to stay non-negative
  function automatic logic [SW-1:0] mod_dec(input logic [SW-1:0] a);
    logic [SW:0] sum_v;
    sum_v = {1'b0, a} + N_EXT - ONE_EXT;
    if (sum_v >= N_EXT) begin
      sum_v = sum_v - N_EXT;
    end else begin
      sum_v = sum_v;
    end
    return sum_v[SW-1:0];
  endfunction

  // (-a) mod N_BANKS; zero maps to zero rather than N_BANKS
  function automatic logic [SW-1:0] mod_neg(input logic [SW-1:0] a);
    logic [SW:0] diff_v;
    if (a == SHIFT_ZERO) begin
      diff_v = {(SW+1){1'b0}};
    end else begin
      diff_v = N_EXT - {1'b0, a};
    end
    return diff_v[SW-1:0];
  endfunction

  // Rotate mask left by STRIDE: bit i moves to (i + STRIDE) mod N_BANKS
  function automatic logic [N_BANKS-1:0] rot_stride(input logic [N_BANKS-1:0] w);
    return {w[N_BANKS-STRIDE-1:0], w[N_BANKS-1:N_BANKS-STRIDE]};
  endfunction

  state_t               state_r;
  state_t               state_nxt_s;
  logic [PW-1:0]        stage_r;
  logic [PW-1:0]        stage_nxt_s;
  logic [AW-1:0]        row_r;
  logic [AW-1:0]        row_nxt_s;
  logic [SW-1:0]        cs1_r;
  logic [SW-1:0]        cs1_nxt_s;
  logic [SW-1:0]        cs2_r;
  logic [SW-1:0]        cs2_nxt_s;
  logic [N_BANKS-1:0]   we_r;
  logic [N_BANKS-1:0]   we_nxt_s;
  logic [N_BANKS-1:0]   we_out_s;
  logic [SW-1:0]        shift_step_s;
  logic                 step_en_s;
  logic                 mode_s;

  assign step_en_s    = (state_r == ST_RUN) && !stall;
  assign mode_s       = (stage_r != STAGE_ZERO);
  assign shift_step_s = mode_s ? mod_add_stride(cs2_r) : mod_dec(cs2_r);

  // State register; reset and clear both force IDLE
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-datapath decode; everything holds unless a step or start occurs
  always_comb begin
    state_nxt_s = state_r;
    stage_nxt_s = stage_r;
    row_nxt_s   = row_r;
    cs1_nxt_s   = cs1_r;
    cs2_nxt_s   = cs2_r;
    we_nxt_s    = we_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          stage_nxt_s = STAGE_ZERO;
          row_nxt_s   = ROW_ZERO;
          cs1_nxt_s   = SHIFT_ZERO;
          cs2_nxt_s   = SHIFT_ZERO;
          we_nxt_s    = WE_INIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (step_en_s) begin
          if (row_r == LAST_ROW) begin
            if (stage_r == LAST_STAGE) begin
              // final step of the final pass: datapath holds, go report completion
              state_nxt_s = ST_DONE;
            end else begin
              // pass boundary: reload the pass-start values with no bubble
              stage_nxt_s = stage_r + STAGE_ONE;
              row_nxt_s   = ROW_ZERO;
              cs1_nxt_s   = SHIFT_ZERO;
              cs2_nxt_s   = SHIFT_ZERO;
              we_nxt_s    = WE_INIT;
            end
          end else begin
            row_nxt_s = row_r + ROW_ONE;
            cs2_nxt_s = shift_step_s;
            cs1_nxt_s = mod_neg(shift_step_s);
            we_nxt_s  = rot_stride(we_r);
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Datapath registers; cleared alongside the state so an abort leaves reset values
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      stage_r <= STAGE_ZERO;
      row_r   <= ROW_ZERO;
      cs1_r   <= SHIFT_ZERO;
      cs2_r   <= SHIFT_ZERO;
      we_r    <= WE_NONE;
    end else begin
      stage_r <= stage_nxt_s;
      row_r   <= row_nxt_s;
      cs1_r   <= cs1_nxt_s;
      cs2_r   <= cs2_nxt_s;
      we_r    <= we_nxt_s;
    end
  end

  // Write-enable view: every bank writes in pass 0, the rotating window afterwards, none outside RUN
  always_comb begin
    we_out_s = WE_NONE;
    if (state_r == ST_RUN) begin
      if (mode_s) begin
        we_out_s = we_r;
      end else begin
        we_out_s = WE_ALL;
      end
    end else begin
      we_out_s = WE_NONE;
    end
  end

  assign busy      = (state_r == ST_RUN);
  assign done      = (state_r == ST_DONE);
  assign step_en   = step_en_s;
  assign stage     = stage_r;
  assign mode      = mode_s;
  assign row       = row_r;
  assign cs1_shift = cs1_r;
  assign cs2_shift = cs2_r;
  assign we        = we_out_s;

endmodule

// File: tb/tb_mem_sched_ctrl.sv
// tb_mem_sched_ctrl
// Directed bench for mem_sched_ctrl at default parameters: plain run, stalled run,
// start pokes during RUN/DONE, clear and reset aborts, each followed by a full run.
module tb_mem_sched_ctrl;

  localparam int N_BANKS = 257;
  localparam int DEPTH   = 85;
  localparam int STRIDE  = 85;
  localparam int PASSES  = 3;
  localparam int SW      = 9;
  localparam int AW      = 7;
  localparam int PW      = 2;
  localparam int TOTAL   = PASSES * DEPTH;

  // hand-computed shift pairs after n completed steps
  localparam int DIR_N   [5] = '{1, 2, 86, 87, 88};
  localparam int DIR_CS2 [5] = '{256, 255, 85, 170, 255};
  localparam int DIR_CS1 [5] = '{1, 2, 172, 87, 2};

  logic               clk = 1'b0;
  logic               reset;
  logic               clear;
  logic               start;
  logic               stall;
  logic               busy;
  logic               done;
  logic               step_en;
  logic [PW-1:0]      stage;
  logic               mode;
  logic [AW-1:0]      row;
  logic [SW-1:0]      cs1_shift;
  logic [SW-1:0]      cs2_shift;
  logic [N_BANKS-1:0] we;

  int checks   = 0;
  int failures = 0;

  mem_sched_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .start     (start),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .step_en   (step_en),
    .stage     (stage),
    .mode      (mode),
    .row       (row),
    .cs1_shift (cs1_shift),
    .cs2_shift (cs2_shift),
    .we        (we)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected cs2 after n completed steps (closed form, not iterated)
  function automatic int model_cs2(input int n);
    int p;
    int j;
    p = n / DEPTH;
    j = n % DEPTH;
    if (p == 0) return (N_BANKS - (j % N_BANKS)) % N_BANKS;
    return (STRIDE * j) % N_BANKS;
  endfunction

  // expected we after n completed steps while in RUN
  function automatic logic [N_BANKS-1:0] model_we(input int n);
    logic [N_BANKS-1:0] m;
    int p;
    int j;
    int off;
    p = n / DEPTH;
    j = n % DEPTH;
    for (int b = 0; b < N_BANKS; b++) begin
      off = (((b - STRIDE * j) % N_BANKS) + N_BANKS) % N_BANKS;
      m[b] = (p == 0) ? 1'b1 : (off < STRIDE);
    end
    return m;
  endfunction

  function automatic logic [N_BANKS-1:0] band(input int lo, input int hi);
    logic [N_BANKS-1:0] m;
    m = {N_BANKS{1'b0}};
    for (int b = lo; b <= hi; b++) m[b] = 1'b1;
    return m;
  endfunction

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_busy"},  busy,      0);
    check_val({tag, "_done"},  done,      0);
    check_val({tag, "_sten"},  step_en,   0);
    check_val({tag, "_stage"}, stage,     0);
    check_val({tag, "_mode"},  mode,      0);
    check_val({tag, "_row"},   row,       0);
    check_val({tag, "_cs1"},   cs1_shift, 0);
    check_val({tag, "_cs2"},   cs2_shift, 0);
    check_val({tag, "_we"},    we,        0);
  endtask

  // One transform from a start pulse. Optional stall window, start pokes, or abort.
  task automatic run_xfer(input string tag, input int stall_n, input int stall_len,
                          input bit poke, input int abort_n, input bit abort_rst);
    int k;
    int n;
    int done_k;
    int pulses;
    int stall_left;
    bit stall_used;
    bit stepped;
    logic [N_BANKS-1:0] we88;
    we88 = band(0, 82) | band(255, 256);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    k = 0; n = 0; done_k = -1; pulses = 0; stall_left = 0; stall_used = 1'b0;
    while (k < 2000) begin
      start = 1'b0;
      stall = 1'b0;
      if (!stall_used && stall_len > 0 && n == stall_n) begin
        stall_left = stall_len;
        stall_used = 1'b1;
      end
      if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end
      if (poke && n == 100 && done_k < 0) start = 1'b1;
      if (poke && done_k >= 0 && k == done_k) start = 1'b1;
      #1;
      if (done_k < 0) begin
        if (done) begin
          done_k = k;
          pulses = 1;
          check_val({tag, "_done_lat"},  k,       TOTAL + stall_len);
          check_val({tag, "_done_busy"}, busy,    0);
          check_val({tag, "_done_sten"}, step_en, 0);
          check_val({tag, "_done_we"},   we,      0);
        end else begin
          check_val({tag, "_busy"},  busy,      1);
          check_val({tag, "_sten"},  step_en,   !stall);
          check_val({tag, "_stage"}, stage,     n / DEPTH);
          check_val({tag, "_mode"},  mode,      (n / DEPTH) != 0);
          check_val({tag, "_row"},   row,       n % DEPTH);
          check_val({tag, "_cs2"},   cs2_shift, model_cs2(n));
          check_val({tag, "_cs1"},   cs1_shift, (N_BANKS - model_cs2(n)) % N_BANKS);
          check_val({tag, "_we"},    we,        model_we(n));
          for (int i = 0; i < 5; i++) begin
            if (n == DIR_N[i]) begin
              check_val({tag, "_dir_cs2"}, cs2_shift, DIR_CS2[i]);
              check_val({tag, "_dir_cs1"}, cs1_shift, DIR_CS1[i]);
            end
          end
          if (n == 1)  check_val({tag, "_we_p0"},  we, {N_BANKS{1'b1}});
          if (n == 84) check_val({tag, "_row84"},  row, 84);
          if (n == 85) check_val({tag, "_we_p1e"}, we, band(0, 84));
          if (n == 86) check_val({tag, "_we_p1a"}, we, band(85, 169));
          if (n == 88) check_val({tag, "_we_p1c"}, we, we88);
        end
      end else begin
        if (done) pulses++;
        check_val({tag, "_after_busy"}, busy, 0);
        if (k == done_k + 3) break;
      end
      if (abort_n >= 0 && done_k < 0 && n == abort_n) begin
        if (abort_rst) reset = 1'b1;
        else clear = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear = 1'b0;
        stall = 1'b0;
        #1;
        check_idle_zero({tag, "_abort"});
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          #1;
          if (done) pulses++;
        end
        check_val({tag, "_abort_pulses"}, pulses, 0);
        check_val({tag, "_abort_busy"},   busy,   0);
        return;
      end
      stepped = step_en;
      @(negedge clk);
      k++;
      if (stepped) n++;
    end
    start = 1'b0;
    stall = 1'b0;
    check_val({tag, "_pulses"}, pulses, 1);
    check_val({tag, "_steps"},  n,      TOTAL);
    check_val({tag, "_seen"},   done_k, TOTAL + stall_len);
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    #1;
    check_val("idle_stall_sten", step_en, 0);
    check_val("idle_stall_busy", busy,    0);
    stall = 1'b0;

    run_xfer("plain",   -1,  0, 1'b0, -1,  1'b0);
    run_xfer("stall",  125, 10, 1'b0, -1,  1'b0);
    run_xfer("poke",    -1,  0, 1'b1, -1,  1'b0);
    run_xfer("clr",     -1,  0, 1'b0, 187, 1'b0);
    run_xfer("postclr", -1,  0, 1'b0, -1,  1'b0);
    run_xfer("rstab",   -1,  0, 1'b0, 187, 1'b1);
    run_xfer("postrst", -1,  0, 1'b0, -1,  1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_sched_ctrl.md
# mem_sched_ctrl

Parametrised memory-bank controller for the non-power-of-two NTT datapath. It sequences a full multi-pass transform autonomously from a single `start` pulse. Each cycle it generates:
- the common row index,
- the two cyclic-shift amounts for the bank crossbars,
- the per-bank write-enable mask.

A per-cycle `stall` input freezes sequencing, and a `done` pulse marks completion. It sits between the top-level NTT sequencer and the N_BANKS single-port coefficient memories.

## Interface
- N_BANKS, default 257, number of memory banks (modulus of all shift arithmetic)
- DEPTH, default 85, rows per bank = steps per pass
- STRIDE, default 85, mode-1 shift increment and width of the write window; 0 < STRIDE < N_BANKS
- PASSES, default 3, passes per transform; pass 0 is mode 0, passes ≥1 are mode 1
- SW, default 9, shift width, ≥ clog2(N_BANKS)
- AW, default 7, row width, ≥ clog2(DEPTH)
- PW, default 2, pass index width, ≥ clog2(PASSES)

Ports (clock and reset first):
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- clear  in  1  synchronous soft reset; same effect as reset
- start  in  1  begin transform; sampled only in IDLE
- stall  in  1  hold the current step (no advance this cycle)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the final step
- step_en  out  1  a step is performed at this clock edge (memory access valid)
- stage  out  PW  current pass index
- mode  out  1  0 when stage==0, else 1
- row  out  AW  row index common to all banks
- cs1_shift  out  SW  read-crossbar shift
- cs2_shift  out  SW  write-crossbar shift
- we  out  N_BANKS  per-bank write enable

## Operation
- States:
  - IDLE: start=1 → RUN.
  - RUN: last step advances → DONE.
  - DONE: always → IDLE.
  - reset or clear: from any state → IDLE.
- On IDLE→RUN: stage=0, row=0, cs1=cs2=0, we_reg = STRIDE ones in bits [STRIDE-1:0], zeros above.
- step_en = (state==RUN) && !stall; purely combinational, no latency.
- On each edge with step_en=1:
  - Not last row (row != DEPTH-1):
    - row += 1.
    - nxt = mode ? (cs2 + STRIDE) mod N_BANKS : (cs2 − 1) mod N_BANKS.
    - cs2 ← nxt.
    - cs1 ← (nxt==0) ? 0 : N_BANKS − nxt.
    - we_reg ← we_reg rotated left by STRIDE (bit i moves to (i+STRIDE) mod N_BANKS).
  - Last row (row == DEPTH-1), stage < PASSES-1:
    - stage += 1.
    - row, cs1, cs2, we_reg reload to their IDLE→RUN values.
  - Last row (row == DEPTH-1), stage == PASSES-1: → DONE; registers hold.
- Modular add/sub uses SW+1-bit intermediates. Results are always in [0, N_BANKS-1], with no wrap artefacts.
- we output:
  - RUN, mode 0: all ones.
  - RUN, mode 1: we_reg.
  - IDLE/DONE: all zeros.
- start is ignored in RUN and DONE. stall is ignored outside RUN. clear and reset have priority over start and stall.

## Timing
- Reset values: busy=0, done=0, step_en=0, stage=0, mode=0, row=0, cs1_shift=0, cs2_shift=0, we=0.
- start high at edge t0 → busy=1 from t0; first step_en at edge t0+1 if stall=0.
- Unstalled transform: exactly PASSES·DEPTH step_en cycles, then done high for exactly one cycle. busy falls in the same cycle done rises.
- Each stalled cycle adds exactly one cycle. Under stall, all registered outputs hold and we holds its value.
- Pass boundary costs no bubble: the first step of pass k+1 immediately follows the last step of pass k.
- All registered outputs are valid for the cycle following the edge that updates them.
- clear or reset mid-run → IDLE with all reset values on the following cycle. The aborted run produces no done pulse.

## Test plan
- Defaults, reset, start with stall=0 → 255 consecutive step_en cycles; stage goes 0→1 after step 85 and 1→2 after step 170; done pulses one cycle after step 255; busy low thereafter.
- Pass 0 shifts → after 1 step cs2=256, cs1=1; after 2 steps cs2=255, cs1=2; we=all ones throughout; row=84 on the 85th step.
- Pass 1 → at entry cs2=0, cs1=0, we bits[84:0]=1. After 1 step: cs2=85, cs1=172, we bits[169:85]=1. After 3 steps: cs2=255, cs1=2, we bits {255,256,0..82}=1.
- stall high for 10 cycles at stage 1, row 40 → step_en=0, and row, shifts and we frozen for 10 cycles; done arrives exactly 10 cycles later than in the unstalled run.
- start asserted during RUN and during DONE → ignored; no restart; single done pulse.
- clear at stage 2, row 17 (and separately reset) → next cycle IDLE, all outputs at reset values, no done pulse; a subsequent start runs a full 255-step transform.
